// File: rtl/vram_feeder_pkg.sv
// vram_feeder_pkg
// Shared types and helpers for the VRAM feeder.
//   state_t    : frame FSM state (IDLE, STREAM)
//   BPP888     : bytes per RGB888 pixel
//   BPP565     : bytes per RGB565 pixel
//   expand565  : 16-bit RGB565 word -> {R8, G8, B8}, MSB replication
package vram_feeder_pkg;

  typedef enum logic {IDLE, STREAM} state_t;

  localparam int BPP888 = 3;
  localparam int BPP565 = 2;

  // Replicating the top channel bits keeps full-scale 565 values at 0xFF.
  function automatic logic [23:0] expand565(input logic [15:0] v);
    return {v[15:11], v[15:13], v[10:5], v[10:9], v[4:0], v[4:2]};
  endfunction

endpackage

// File: rtl/vram_feeder_pixel_unpack.sv
// pixel_unpack
// Little-endian byte queue that turns 64-bit words into a byte stream.
// Ports:
//   clk_sys, reset : clock and synchronous active-high reset
//   flush          : empty the queue (level -> 0)
//   push           : append the 8 bytes of push_data after the current bytes
//   push_data      : packed word, byte 0 = bits [7:0] = earliest byte
//   pop            : drop pop_bpp bytes from the head this cycle
//   pop_bpp        : number of bytes to drop (2 or 3)
//   head           : head three bytes, {byte2, byte1, byte0}
//   level          : number of valid bytes held (0..BUF_BYTES)
module pixel_unpack #(
  parameter int BUF_BYTES = 16,
  parameter int LVL_W     = $clog2(BUF_BYTES + 1)
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [63:0]      push_data,
  input  logic             pop,
  input  logic [1:0]       pop_bpp,
  output logic [23:0]      head,
  output logic [LVL_W-1:0] level
);

  logic [7:0]       mem     [BUF_BYTES];
  logic [7:0]       mem_nxt [BUF_BYTES];
  logic [LVL_W-1:0] keep;
  int               shift;

  // Pop shifts the queue toward the head first; the pushed word is then
  // written just past the bytes that survive the pop.
  always_comb begin
    keep  = pop ? level - LVL_W'(pop_bpp) : level;
    shift = pop ? int'(pop_bpp) : 0;
    for (int i = 0; i < BUF_BYTES; i++) begin
      mem_nxt[i] = 8'h00;
      for (int j = 0; j < BUF_BYTES; j++) begin
        if (j == i + shift) mem_nxt[i] = mem[j];
      end
      for (int k = 0; k < 8; k++) begin
        if (push && (i == int'(keep) + k)) mem_nxt[i] = push_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      level <= '0;
    end else begin
      level <= push ? keep + LVL_W'(8) : keep;
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < BUF_BYTES; i++) mem[i] <= mem_nxt[i];
  end

  assign head = {mem[2], mem[1], mem[0]};

endmodule

// File: rtl/vram_feeder.sv
// vram_feeder
// Unpacks a 64-bit packed pixel word stream into RGB888/RGB565 pixels and
// writes one pixel per request into the vga VRAM write port.
// Ports:
//   clk_sys, reset     : clock and synchronous active-high reset
//   frame_start        : pulse; starts (or aborts and restarts) a frame
//   rgb565             : pixel format, 1 = RGB565, 0 = RGB888 (latched)
//   H, V               : visible width / height (latched)
//   word_data/valid    : packed word source
//   word_ready         : word accepted this cycle when word_valid is high
//   vram_ready         : vga write side can take a pixel
//   vram_req           : pixel write request (combinational)
//   r/g/b_vram_out     : pixel requested last cycle, held until next request
//   busy               : frame in progress
//   frame_done         : pulse with the final request of a frame
//   pixel_count        : pixels requested in the current frame
module vram_feeder
  import vram_feeder_pkg::*;
#(
  parameter int BUF_BYTES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        rgb565,
  input  logic [15:0] H,
  input  logic [15:0] V,
  input  logic [63:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        vram_ready,
  output logic        vram_req,
  output logic [7:0]  r_vram_out,
  output logic [7:0]  g_vram_out,
  output logic [7:0]  b_vram_out,
  output logic        busy,
  output logic        frame_done,
  output logic [23:0] pixel_count
);

  localparam int LVL_W = $clog2(BUF_BYTES + 1);

  state_t           state;
  logic             fmt_565;
  logic [23:0]      total;
  logic [23:0]      words_needed;
  logic [23:0]      words_fetched;
  logic [23:0]      total_calc;
  logic [26:0]      bytes_calc;
  logic [23:0]      words_calc;
  logic [1:0]       bpp;
  logic [LVL_W-1:0] level;
  logic [23:0]      head;
  logic [23:0]      pix_next;
  logic             active;
  logic             push;
  logic             flush;

  // Frame geometry from the live inputs, captured on frame_start.
  always_comb begin
    total_calc = {8'h00, H} * {8'h00, V};
    bytes_calc = {3'b000, total_calc} * (rgb565 ? 27'd2 : 27'd3);
    words_calc = 24'((bytes_calc + 27'd7) >> 3);
  end

  assign bpp = fmt_565 ? 2'(BPP565) : 2'(BPP888);

  // A restart or reset cycle moves no data: the buffer is about to be flushed,
  // so neither a word nor a pixel from the old frame may be consumed.
  assign active = (state == STREAM) && !frame_start && !reset;

  assign word_ready = active && (level <= LVL_W'(BUF_BYTES - 8))
                      && (words_fetched < words_needed);
  assign vram_req   = active && vram_ready
                      && (level >= {{(LVL_W-2){1'b0}}, bpp})
                      && (pixel_count < total);
  assign frame_done = active && ((vram_req && (pixel_count + 24'd1 == total))
                                 || (total == 24'd0));
  assign busy       = (state == STREAM);
  assign push       = word_valid && word_ready;

  // Padding bytes of the last word are dropped when the frame ends.
  assign flush      = frame_start || frame_done;

  assign pix_next = fmt_565 ? expand565(head[15:0])
                            : {head[7:0], head[15:8], head[23:16]};

  pixel_unpack #(
    .BUF_BYTES (BUF_BYTES),
    .LVL_W     (LVL_W)
  ) u_unpack (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (word_data),
    .pop       (vram_req),
    .pop_bpp   (bpp),
    .head      (head),
    .level     (level)
  );

  // Frame FSM, counters and the registered pixel outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state         <= IDLE;
      fmt_565       <= 1'b0;
      total         <= '0;
      words_needed  <= '0;
      words_fetched <= '0;
      pixel_count   <= '0;
      r_vram_out    <= 8'h00;
      g_vram_out    <= 8'h00;
      b_vram_out    <= 8'h00;
    end else if (frame_start) begin
      state         <= STREAM;
      fmt_565       <= rgb565;
      total         <= total_calc;
      words_needed  <= words_calc;
      words_fetched <= '0;
      pixel_count   <= '0;
    end else if (state == STREAM) begin
      if (push) words_fetched <= words_fetched + 24'd1;
      if (vram_req) begin
        pixel_count <= pixel_count + 24'd1;
        r_vram_out  <= pix_next[23:16];
        g_vram_out  <= pix_next[15:8];
        b_vram_out  <= pix_next[7:0];
      end
      if (frame_done) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_vram_feeder.sv
// tb_vram_feeder
// Scoreboard bench for vram_feeder: expected pixels are queued as the word
// stream is loaded and popped whenever the DUT presents a requested pixel.
module tb_vram_feeder;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        rgb565;
  logic [15:0] H;
  logic [15:0] V;
  logic [63:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        vram_ready;
  logic        vram_req;
  logic [7:0]  r_vram_out;
  logic [7:0]  g_vram_out;
  logic [7:0]  b_vram_out;
  logic        busy;
  logic        frame_done;
  logic [23:0] pixel_count;

  vram_feeder #(.BUF_BYTES(16)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .frame_start (frame_start),
    .rgb565      (rgb565),
    .H           (H),
    .V           (V),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .vram_ready  (vram_ready),
    .vram_req    (vram_req),
    .r_vram_out  (r_vram_out),
    .g_vram_out  (g_vram_out),
    .b_vram_out  (b_vram_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .pixel_count (pixel_count)
  );

  always #5 clk_sys = ~clk_sys;

  logic [23:0] exp_q[$];
  logic [63:0] src_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_req, n_acc, fd_cnt, fd_at, cyc;
  int bad_req  = 0;
  int hold_bad = 0;
  int wr_late, wr_low, acc_lim;
  int bp_lo = 1000;
  int bp_hi = 1000;
  logic        src_en;
  logic        hold_chk = 1'b0;
  logic        last_fd;
  logic [23:0] last_rgb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clear_counts();
    n_req = 0; n_acc = 0; fd_cnt = 0; fd_at = 0; cyc = 0;
    wr_late = 0; wr_low = 0; acc_lim = 1 << 30;
  endtask

  task automatic drive_src();
    word_valid = src_en && (src_q.size() > 0);
    word_data  = (src_q.size() > 0) ? src_q[0] : 64'h0;
    vram_ready = !(cyc >= bp_lo && cyc <= bp_hi);
  endtask

  // One clock: inputs settle after the falling edge, the DUT's view of the
  // coming rising edge is sampled 1 time unit later, and registered results
  // are inspected 1 time unit after the rising edge.
  task automatic step();
    logic acc;
    logic req;
    logic [23:0] e;
    drive_src();
    #1;
    acc     = word_valid && word_ready;
    req     = vram_req;
    last_fd = frame_done;
    if (req && !vram_ready) bad_req++;
    if (busy && !word_ready && (src_q.size() > 0)) wr_low++;
    if (n_acc >= acc_lim && word_ready) wr_late++;
    if (acc) n_acc++;
    if (req) n_req++;
    if (frame_done) begin
      fd_cnt++;
      fd_at = n_req;
    end
    @(posedge clk_sys);
    #1;
    if (req) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pixel", {r_vram_out, g_vram_out, b_vram_out}, 24'hxxxxxx);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", {r_vram_out, g_vram_out, b_vram_out}, e);
      end
    end else if (hold_chk && ({r_vram_out, g_vram_out, b_vram_out} != last_rgb)) begin
      hold_bad++;
    end
    last_rgb = {r_vram_out, g_vram_out, b_vram_out};
    if (acc) void'(src_q.pop_front());
    cyc++;
    @(negedge clk_sys);
  endtask

  task automatic load888(input logic [7:0] base, input int nwords, input int npix);
    logic [63:0] w;
    for (int k = 0; k < nwords; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w[8*j +: 8] = base + 8'(8*k + j);
      src_q.push_back(w);
    end
    for (int p = 0; p < npix; p++)
      exp_q.push_back({base + 8'(3*p), base + 8'(3*p + 1), base + 8'(3*p + 2)});
  endtask

  task automatic start_frame(input logic [15:0] h, input logic [15:0] v, input logic fmt);
    H = h; V = v; rgb565 = fmt;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 200 && fd_cnt == 0; i++) step();
    if (fd_cnt == 0) chk("frame_timeout", 64'd0, 64'd1);
    step();
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; rgb565 = 1'b0; H = '0; V = '0;
    word_data = '0; word_valid = 1'b0; vram_ready = 1'b1; src_en = 1'b1;
    last_fd = 1'b0; last_rgb = '0;
    clear_counts();
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    #1;
    chk("rst_vram_req", vram_req, 0);
    chk("rst_word_ready", word_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pixel_count", pixel_count, 0);
    chk("rst_rgb", {r_vram_out, g_vram_out, b_vram_out}, 24'h000000);
    @(negedge clk_sys);

    // RGB888 4x2, bytes 0x00..0x17
    clear_counts(); acc_lim = 3;
    load888(8'h00, 3, 8);
    start_frame(16'd4, 16'd2, 1'b0);
    finish_frame();
    chk("t1_reqs", n_req, 8);
    chk("t1_words", n_acc, 3);
    chk("t1_done_at", fd_at, 8);
    chk("t1_done_cnt", fd_cnt, 1);
    chk("t1_ready_late", wr_late, 0);
    chk("t1_pixel_count", pixel_count, 8);
    chk("t1_busy", busy, 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // RGB565 3x1, one word, bytes 6-7 discarded
    clear_counts();
    src_q.push_back(64'h0000_F800_07E0_001F);
    exp_q.push_back(24'h0000FF);
    exp_q.push_back(24'h00FF00);
    exp_q.push_back(24'hFF0000);
    start_frame(16'd3, 16'd1, 1'b1);
    finish_frame();
    chk("t2_reqs", n_req, 3);
    chk("t2_words", n_acc, 1);
    chk("t2_pixel_count", pixel_count, 3);
    chk("t2_done_cnt", fd_cnt, 1);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Backpressure: vram_ready low for frame cycles 5..9
    clear_counts(); acc_lim = 3;
    bp_lo = 5; bp_hi = 9; hold_chk = 1'b1;
    load888(8'h40, 3, 8);
    start_frame(16'd4, 16'd2, 1'b0);
    finish_frame();
    hold_chk = 1'b0; bp_lo = 1000; bp_hi = 1000;
    chk("t3_req_while_not_ready", bad_req, 0);
    chk("t3_rgb_hold", hold_bad, 0);
    chk("t3_word_ready_dropped", (wr_low > 0), 1);
    chk("t3_reqs", n_req, 8);
    chk("t3_words", n_acc, 3);
    chk("t3_done_cnt", fd_cnt, 1);
    chk("t3_sb_empty", exp_q.size(), 0);

    // Abort after 5 of 8 pixels, restart with a fresh stream
    clear_counts();
    load888(8'h80, 3, 8);
    start_frame(16'd4, 16'd2, 1'b0);
    for (int i = 0; i < 100 && n_req < 5; i++) step();
    chk("t4_reached_5", n_req, 5);
    exp_q.delete();
    src_q.delete();
    load888(8'hC0, 3, 8);
    start_frame(16'd4, 16'd2, 1'b0);
    chk("t4_abort_no_done", fd_cnt, 0);
    chk("t4_abort_count", pixel_count, 0);
    chk("t4_abort_busy", busy, 1);
    clear_counts();
    finish_frame();
    chk("t4_reqs", n_req, 8);
    chk("t4_done_cnt", fd_cnt, 1);
    chk("t4_sb_empty", exp_q.size(), 0);

    // Reset with frame_start in the same cycle mid-STREAM
    clear_counts();
    load888(8'h20, 3, 8);
    start_frame(16'd4, 16'd2, 1'b0);
    repeat (3) step();
    reset = 1'b1; frame_start = 1'b1;
    step();
    reset = 1'b0; frame_start = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_vram_req", vram_req, 0);
    chk("t5_word_ready", word_ready, 0);
    chk("t5_frame_done", frame_done, 0);
    chk("t5_pixel_count", pixel_count, 0);
    chk("t5_rgb", {r_vram_out, g_vram_out, b_vram_out}, 24'h000000);
    chk("t5_no_done", fd_cnt, 0);
    @(negedge clk_sys);
    exp_q.delete();
    src_q.delete();

    // Zero-size frame: done one cycle after frame_start, no data moved
    clear_counts();
    src_q.push_back(64'hDEAD_BEEF_0123_4567);
    start_frame(16'd0, 16'd5, 1'b0);
    step();
    chk("t6_done_next_cycle", last_fd, 1);
    repeat (3) step();
    chk("t6_done_cnt", fd_cnt, 1);
    chk("t6_reqs", n_req, 0);
    chk("t6_words", n_acc, 0);
    chk("t6_busy", busy, 0);
    src_q.delete();

    chk("req_gated_by_ready", bad_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
